pwm_multichannel_gen: RTL
=========================

// Module: pwm_multichannel_gen
// PURPOSE
//   Next-generation PWM generator for the onboarding peripheral.
//   - CHANNELS independent outputs share one prescaled counter; duty resolution is WIDTH bits.
//   - Adds double-buffered (glitch-free) duty updates, edge/centre-aligned modes and per-channel polarity.
//   - Sits behind the SPI register file; drives uo_out/uio_out through the top-level wrapper.
// PARAMETERS
//   CHANNELS  16  number of PWM outputs
//   WIDTH     8   duty/counter width in bits; period = 2^WIDTH-1 ticks (edge mode)
//   DIV_W     12  prescaler width in bits
// PORTS
//   clk        in   1             system clock
//   rst        in   1             asynchronous, active-high reset
//   prescale   in   DIV_W         tick every prescale+1 clk cycles
//   centre     in   1             0=edge-aligned, 1=centre-aligned; sampled at period start
//   en_out     in   CHANNELS      per-channel output enable; 0 forces inactive level
//   en_pwm     in   CHANNELS      1=PWM, 0=static active level (when en_out=1)
//   invert     in   CHANNELS      1=active-low output
//   duty       in   CHANNELS*WIDTH  flattened duty; channel i at [i*WIDTH +: WIDTH]
//   pwm_out    out  CHANNELS      registered PWM outputs
//   period_start out 1            1-cycle pulse on the tick that starts a period
// BEHAVIOUR
//   Reset (async): all outputs 0, prescaler 0, cnt 0, dir up, shadow duties 0, mode latched edge.
//   Prescaler
//     - counts 0..prescale; tick when it equals prescale, then wraps to 0.
//     - prescale=0 => tick every cycle.
//     - prescale reduced below current count => wrap at next compare-equal or all-ones, whichever first.
//   Edge mode: on tick, cnt increments 0..2^WIDTH-2 then wraps to 0.
//   Centre mode
//     - on tick, cnt counts up 0..2^WIDTH-2, then down to 1, then up from 0.
//     - period = 2*(2^WIDTH-2) ticks.
//   Period start = tick while cnt==0 (both modes).
//     - On period start: shadow_duty[i] <= duty[i] for all i; mode latched from centre; period_start=1 that cycle.
//     - duty writes mid-period never affect the current period.
//   Per channel, raw = (cnt < shadow_duty[i]).
//     - duty 0 => always low.
//     - duty all-ones => always high (cnt never reaches 2^WIDTH-1).
//   Output
//     - act = en_pwm ? raw : 1.
//     - pwm_out[i] <= en_out[i] ? (act ^ invert[i]) : invert[i].
//     - Registered: pwm_out reflects cnt/shadow of the previous cycle (1-cycle latency).
//     - en_out/en_pwm/invert are NOT double-buffered: they take effect one cycle after change.
//   Mode change takes effect only at period start; cnt/dir are never reset by a mode change.
//   Reset asserted mid-period: immediate return to reset state; first period_start occurs
//     on first tick after release.
//   Simultaneous duty write and period start: the new value is captured (write visible same cycle).
// STRUCTURE
//   - Shared package pwm_pkg: mode encoding (PWM_EDGE=0, PWM_CENTRE=1), default parameter constants.
//   - Sub-module pwm_timebase: prescaler + counter + direction + period_start; one instance.
//   - The top contains the shadow registers and per-channel compare/output logic via generate loop.
// TESTING
//   1. WIDTH=8, prescale=0, edge, duty[0]=64, en_out=en_pwm=1
//      -> pwm_out[0] high 64 of every 255 cycles; period_start every 255 cycles.
//   2. duty=0 and duty=255 on two channels -> constant 0 and constant 1; invert=1 flips both;
//      en_out=0 gives invert level.
//   3. Change duty[0] 64->200 mid-period
//      -> current period keeps 64-high; next period (after period_start) shows 200-high.
//   4. centre=1, duty=100, prescale=0
//      -> period 508 cycles, single high pulse of 199 cycles centred on cnt=0 crossing;
//      mode switch only at period start.
//   5. prescale=2999 -> counter advances once per 3000 clk; period_start spacing 765000 cycles (WIDTH=8).
//   6. Assert rst mid-period (async, between clk edges) -> pwm_out and period_start 0 immediately;
//      after release first period_start after prescale+1 cycles.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the multichannel PWM generator: counting mode
// encoding and the default sizing used when the top is instantiated bare.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTRE = 1'b1
  } pwm_mode_e;

  localparam int DEF_CHANNELS = 16;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DIV_W    = 12;

endpackage

// File: rtl/pwm_timebase.sv
// Shared timebase: prescaler, up/up-down counter with direction, latched
// counting mode and the period-start strobe that all channels key off.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] prescale_i,
  input  logic             centre_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             period_start_o
);

  // Highest count value; all-ones is never reached so a full-scale duty stays high.
  localparam logic [WIDTH-1:0] CNT_TOP = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [DIV_W-1:0] preCnt_q, preCnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dirUp_q, dirUp_d;
  pwm_mode_e        mode_q, mode_d;
  logic             tick;
  logic             periodStart;

  // Tick on compare-equal, or on all-ones so a shrunken prescale still wraps;
  // held off while reset is asserted so no strobe leaks out during reset.
  always_comb begin
    tick        = 1'b0;
    periodStart = 1'b0;
    if (!rst_i) begin
      tick        = (preCnt_q == prescale_i) || (preCnt_q == '1);
      periodStart = tick && (cnt_q == '0);
    end
  end

  // Next-state for prescaler, counter, direction and latched mode.
  always_comb begin
    preCnt_d = tick ? '0 : preCnt_q + DIV_W'(1);
    cnt_d    = cnt_q;
    dirUp_d  = dirUp_q;
    mode_d   = mode_q;
    if (tick) begin
      if (periodStart) begin
        mode_d = centre_i ? PWM_CENTRE : PWM_EDGE;
      end
      if (mode_q == PWM_CENTRE) begin
        if (dirUp_q) begin
          if (cnt_q == CNT_TOP) begin
            cnt_d   = cnt_q - WIDTH'(1);
            dirUp_d = 1'b0;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else begin
          if (cnt_q <= WIDTH'(1)) begin
            cnt_d   = '0;
            dirUp_d = 1'b1;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end else begin
        cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + WIDTH'(1);
      end
    end
  end

  // Timebase state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      preCnt_q <= '0;
      cnt_q    <= '0;
      dirUp_q  <= 1'b1;
      mode_q   <= PWM_EDGE;
    end else begin
      preCnt_q <= preCnt_d;
      cnt_q    <= cnt_d;
      dirUp_q  <= dirUp_d;
      mode_q   <= mode_d;
    end
  end

  assign cnt_o          = cnt_q;
  assign period_start_o = periodStart;

endmodule

// File: rtl/pwm_multichannel_gen.sv
// Multichannel PWM generator: one shared timebase, per-channel shadowed duty
// loaded only at period start, compare, enable/polarity and registered output.
module pwm_multichannel_gen
  import pwm_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DIV_W    = DEF_DIV_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DIV_W-1:0]          prescale_i,
  input  logic                      centre_i,
  input  logic [CHANNELS-1:0]       en_out_i,
  input  logic [CHANNELS-1:0]       en_pwm_i,
  input  logic [CHANNELS-1:0]       invert_i,
  input  logic [CHANNELS*WIDTH-1:0] duty_i,
  output logic [CHANNELS-1:0]       pwm_out_o,
  output logic                      period_start_o
);

  logic [WIDTH-1:0]    cnt;
  logic                periodStart;
  logic [CHANNELS-1:0] pwmOut_d, pwmOut_q;

  pwm_timebase #(
    .WIDTH (WIDTH),
    .DIV_W (DIV_W)
  ) u_timebase (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .prescale_i     (prescale_i),
    .centre_i       (centre_i),
    .cnt_o          (cnt),
    .period_start_o (periodStart)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [WIDTH-1:0] shadowDuty_q;
    logic             raw;
    logic             act;

    // Shadow duty only follows the live input at period start, so mid-period writes wait.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        shadowDuty_q <= '0;
      end else if (periodStart) begin
        shadowDuty_q <= duty_i[i*WIDTH +: WIDTH];
      end
    end

    assign raw         = (cnt < shadowDuty_q);
    assign act         = en_pwm_i[i] ? raw : 1'b1;
    assign pwmOut_d[i] = en_out_i[i] ? (act ^ invert_i[i]) : invert_i[i];
  end

  // Output register keeps the pins glitch-free at the cost of one cycle latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pwmOut_q <= '0;
    end else begin
      pwmOut_q <= pwmOut_d;
    end
  end

  assign pwm_out_o      = pwmOut_q;
  assign period_start_o = periodStart;

endmodule
